// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide issue controller:
// op-class codes, controller states, default unit latencies and op helpers.
package md_issue_ctrl_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_t;

  localparam int unsigned MD_MULT_LAT_DEF  = 32'd5;
  localparam int unsigned MD_DIV_LAT_DEF   = 32'd10;
  localparam int unsigned MD_ABORT_WIN_DEF = 32'd2;

  function automatic logic md_is_start(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic md_is_hilo(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Codes 9-15 carry no HI/LO meaning and are squashed to MD_NONE.
  function automatic logic [3:0] md_legal(input logic [3:0] op);
    return md_is_hilo(op) ? op : MD_NONE;
  endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Occupancy timer for the mult/div unit: remaining-cycle down-counter plus
// cycles-since-start counter, with end-of-operation and abort-window flags.
module md_lat_counter #(
  parameter int unsigned CW        = 4,
  parameter int unsigned ABORT_WIN = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          abort,
  input  logic          dec,
  output logic          last,
  output logic          in_win
);

  localparam logic [CW-1:0] ZERO = CW'(32'd0);
  localparam logic [CW-1:0] ONE  = CW'(32'd1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] elapsed_r;

  // Abort wins over a fresh load, which wins over the countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= ZERO;
      elapsed_r <= ZERO;
    end else if (abort) begin
      cnt_r     <= ZERO;
      elapsed_r <= ZERO;
    end else if (load) begin
      cnt_r     <= load_val;
      elapsed_r <= ONE;
    end else if (dec) begin
      if (cnt_r > ONE) begin
        cnt_r     <= cnt_r - ONE;
        elapsed_r <= elapsed_r + ONE;
      end else begin
        cnt_r     <= ZERO;
        elapsed_r <= ZERO;
      end
    end else begin
      cnt_r     <= cnt_r;
      elapsed_r <= elapsed_r;
    end
  end

  // Flags derived from the current count; cnt<=1 also guards a 1-cycle latency.
  always_comb begin
    last   = (cnt_r <= ONE);
    in_win = (32'(elapsed_r) < ABORT_WIN);
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/hazard controller for the shared HI/LO multiply/divide unit: D->E op
// register, start strobe, occupancy tracking, D-stage stall and abort.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT  = MD_MULT_LAT_DEF,
  parameter int unsigned DIV_LAT   = MD_DIV_LAT_DEF,
  parameter int unsigned ABORT_WIN = MD_ABORT_WIN_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_opD,
  input  logic        flushE,
  input  logic        Exception,
  output logic        stallD,
  output logic [3:0]  md_opE,
  output logic        startE,
  output logic        md_busy,
  output logic        md_done,
  output logic        md_abort,
  output logic [31:0] stall_cnt
);

  localparam int unsigned   MAX_LAT   = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int unsigned   CW        = $clog2(MAX_LAT + 32'd1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 32'd1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 32'd1);
  localparam logic          START_WIN = (ABORT_WIN != 32'd0);

  md_state_t     state_r;
  logic          run_s;
  logic          abort_s;
  logic          last_s;
  logic          in_win_s;
  logic [CW-1:0] load_val_s;

  // Start strobe, occupancy, HI/LO hazard stall and abort qualification.
  always_comb begin
    startE  = md_is_start(md_opE);
    run_s   = (state_r == RUN);
    md_busy = startE | run_s;
    stallD  = md_is_hilo(md_opD) & md_busy;
    abort_s = Exception & ((startE & START_WIN) | (run_s & in_win_s));
    if (md_is_div(md_opE)) begin
      load_val_s = DIV_LOAD;
    end else begin
      load_val_s = MULT_LOAD;
    end
  end

  md_lat_counter #(
    .CW        (CW),
    .ABORT_WIN (ABORT_WIN)
  ) u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (startE),
    .load_val (load_val_s),
    .abort    (abort_s),
    .dec      (run_s),
    .last     (last_s),
    .in_win   (in_win_s)
  );

  // Controller FSM with registered done/abort pulses; abort has top priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      md_done  <= 1'b0;
      md_abort <= 1'b0;
    end else if (abort_s) begin
      state_r  <= IDLE;
      md_done  <= 1'b0;
      md_abort <= 1'b1;
    end else begin
      md_abort <= 1'b0;
      case (state_r)
        IDLE: begin
          md_done <= 1'b0;
          if (startE) begin
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (last_s) begin
            state_r <= IDLE;
            md_done <= 1'b1;
          end else begin
            state_r <= RUN;
            md_done <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          md_done <= 1'b0;
        end
      endcase
    end
  end

  // D->E op register; a stalled or flushed slot becomes a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_opE <= MD_NONE;
    end else if (flushE | stallD) begin
      md_opE <= MD_NONE;
    end else begin
      md_opE <= md_legal(md_opD);
    end
  end

  // Saturating count of stalled D cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stallD && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule
